// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: datapath width, register index width and
// the writeback result-source encodings.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [1:0] RESULTSRC_ALU  = 2'b00;
  localparam logic [1:0] RESULTSRC_MEM  = 2'b01;
  localparam logic [1:0] RESULTSRC_PC4  = 2'b10;
  localparam logic [1:0] RESULTSRC_RSVD = 2'b11;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read one-write architectural register file with x0 hardwired to zero
// and write-first bypass on both read ports.
module regfile_2r1w #(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned NREG  = 32,
  parameter int unsigned IDX_W = riscv_pkg::REG_IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [IDX_W-1:0] raddr1_i,
  input  logic [IDX_W-1:0] raddr2_i,
  output logic [XLEN-1:0]  rdata1_o,
  output logic [XLEN-1:0]  rdata2_o
);

  logic [XLEN-1:0] regs_q [NREG];

  // Entry 0 is never written (caller guarantees waddr_i != 0 when we_i), so it stays zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (we_i && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (we_i && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result, commits it to the register file and keeps
// a retire counter, a last-write trace record and a sticky illegal-Resultsrc flag.
module wb_regfile #(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wb_valid,
  input  logic [XLEN-1:0]                   wb_PCplus4,
  input  logic [XLEN-1:0]                   wb_Data_Out,
  input  logic [XLEN-1:0]                   wb_ALU_Out,
  input  logic [riscv_pkg::REG_IDX_W-1:0]   wb_dest_reg,
  input  logic                              wb_regWrite,
  input  logic [1:0]                        wb_Resultsrc,
  input  logic [riscv_pkg::REG_IDX_W-1:0]   rs1_addr,
  input  logic [riscv_pkg::REG_IDX_W-1:0]   rs2_addr,
  output logic [XLEN-1:0]                   rs1_data,
  output logic [XLEN-1:0]                   rs2_data,
  output logic [XLEN-1:0]                   wb_result,
  output logic [CNT_W-1:0]                  retire_count,
  output logic                              last_wr_valid,
  output logic [riscv_pkg::REG_IDX_W-1:0]   last_wr_reg,
  output logic [XLEN-1:0]                   last_wr_data,
  output logic                              err_resultsrc
);

  import riscv_pkg::*;

  logic                 do_wr;
  logic [CNT_W-1:0]     retire_d, retire_q;
  logic                 lwv_d, lwv_q;
  logic [REG_IDX_W-1:0] lwr_d, lwr_q;
  logic [XLEN-1:0]      lwd_d, lwd_q;
  logic                 err_d, err_q;

  always_comb begin
    wb_result = '0;
    case (wb_Resultsrc)
      RESULTSRC_ALU: wb_result = wb_ALU_Out;
      RESULTSRC_MEM: wb_result = wb_Data_Out;
      RESULTSRC_PC4: wb_result = wb_PCplus4;
      default:       wb_result = '0;
    endcase
  end

  assign do_wr = wb_valid & wb_regWrite & (wb_dest_reg != '0) &
                 (wb_Resultsrc != RESULTSRC_RSVD);

  always_comb begin
    retire_d = retire_q;
    lwv_d    = lwv_q;
    lwr_d    = lwr_q;
    lwd_d    = lwd_q;
    err_d    = err_q;
    // Every valid instruction retires, including x0 writes and illegal Resultsrc.
    if (wb_valid) begin
      retire_d = retire_q + CNT_W'(1);
      if (wb_Resultsrc == RESULTSRC_RSVD) begin
        err_d = 1'b1;
      end
    end
    if (do_wr) begin
      lwv_d = 1'b1;
      lwr_d = wb_dest_reg;
      lwd_d = wb_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_q <= '0;
      lwv_q    <= 1'b0;
      lwr_q    <= '0;
      lwd_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      retire_q <= retire_d;
      lwv_q    <= lwv_d;
      lwr_q    <= lwr_d;
      lwd_q    <= lwd_d;
      err_q    <= err_d;
    end
  end

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREG  (NREG),
    .IDX_W (REG_IDX_W)
  ) u_regfile (
    .clk_i    (clk),
    .rst_ni   (reset),
    .we_i     (do_wr),
    .waddr_i  (wb_dest_reg),
    .wdata_i  (wb_result),
    .raddr1_i (rs1_addr),
    .raddr2_i (rs2_addr),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  assign retire_count  = retire_q;
  assign last_wr_valid = lwv_q;
  assign last_wr_reg   = lwr_q;
  assign last_wr_data  = lwd_q;
  assign err_resultsrc = err_q;

endmodule
